// File: rtl/sm_key_sampler.sv
`default_nettype none
// ============================================================================
// Module   : sm_key_sampler
// Purpose  : Board input sampler. Raw asynchronous pins (KEY/SW style) are
//            brought into the clk domain by a two-flop synchronizer. Each bit
//            is debounced by its own counter, and rising edges of the
//            debounced level are caught in a sticky event register. The CPU
//            reads the level or the event register through a one-cycle read
//            port. A read of the event register clears it.
// Ports    : clk      - core clock
//            rst_n    - asynchronous active-low reset
//            pinIn    - raw pins, WIDTH bits, no polarity inversion
//            rd       - read strobe, sampled on rising clk
//            addr     - 0 = debounced level, 1 = event register
//            rdData   - read result, zero-extended to 32 bits
//            rdValid  - one-cycle pulse marking fresh rdData
//            irq      - OR of all event bits
// Config   : define SM_KEY_SAMPLER_EVENT_EN to build the event register,
//            read-to-clear and irq. Without it, event reads return 0 and irq
//            is tied low. Level reads and debounce are the same in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module sm_key_sampler #(
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 16,
  parameter int DB_LIMIT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pinIn,
  input  logic             rd,
  input  logic             addr,
  output logic [31:0]      rdData,
  output logic             rdValid,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] update;      // per-bit debounce limit reached this cycle
  logic [WIDTH-1:0] evt_view;    // event register as seen by the read port
  logic [31:0]      level_ext, event_ext;
  logic [31:0]      rdData_q, rdData_d;
  logic             rdValid_q, rdValid_d;

  // --------------------------------------------------------------------------
  // Per-bit debounce counter. Any cycle in agreement with the stable level
  // clears the count, so a pending change must be seen DB_LIMIT times in a row.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch;

    assign mismatch  = sync2_q[i] != stable_q[i];
    assign update[i] = mismatch && (cnt_q == CNT_LAST);
    assign cnt_d     = (!mismatch || update[i]) ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // An update only happens on a mismatch, so flipping the bit adopts sync2.
  assign stable_d = stable_q ^ update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= pinIn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

`ifdef SM_KEY_SAMPLER_EVENT_EN
  // --------------------------------------------------------------------------
  // Sticky rising-edge events. Set has priority over read-to-clear so a rise
  // landing on the same edge as an event read is never lost.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] rise, clr, evt_q, evt_d;

  assign rise  = update & sync2_q;
  assign clr   = {WIDTH{rd & addr}};
  assign evt_d = (evt_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_view = evt_q;
  assign irq      = |evt_q;
`else
  assign evt_view = '0;
  assign irq      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read port: returns pre-update register values, holds data between reads.
  // --------------------------------------------------------------------------
  always_comb begin
    level_ext            = '0;
    event_ext            = '0;
    level_ext[WIDTH-1:0] = stable_q;
    event_ext[WIDTH-1:0] = evt_view;
  end

  assign rdData_d  = rd ? (addr ? event_ext : level_ext) : rdData_q;
  assign rdValid_d = rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign rdData  = rdData_q;
  assign rdValid = rdValid_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_key_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_key_sampler
// Purpose  : Self-checking bench for sm_key_sampler (WIDTH=4, DB_LIMIT=4).
//            Read requests push their hand-computed expected data into a
//            queue. A monitor pops and compares on every rdValid. Direct
//            checks cover irq timing and asynchronous reset. Event-related
//            expectations follow SM_KEY_SAMPLER_EVENT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_key_sampler;

  localparam int WIDTH    = 4;
  localparam int CNT_W    = 8;
  localparam int DB_LIMIT = 4;
`ifdef SM_KEY_SAMPLER_EVENT_EN
  localparam logic EV = 1'b1;
`else
  localparam logic EV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pinIn;
  logic             rd;
  logic             addr;
  logic [31:0]      rdData;
  logic             rdValid;
  logic             irq;

  int               n_total = 0;
  int               n_pass  = 0;
  logic [31:0]      exp_q[$];
  string            name_q[$];

  sm_key_sampler #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .DB_LIMIT(DB_LIMIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pinIn  (pinIn),
    .rd     (rd),
    .addr   (addr),
    .rdData (rdData),
    .rdValid(rdValid),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the read is sampled on the following posedge.
  task automatic rd_issue(input string name, input logic a, input logic [31:0] exp);
    rd   = 1'b1;
    addr = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    rd   = 1'b0;
    addr = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rdValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected: rdValid with data 0x%08h but no read pending", rdData);
        end else begin
          chk(name_q.pop_front(), rdData, exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    pinIn = '0;
    rd    = 1'b0;
    addr  = 1'b0;
    #1;
    chk("rst_rdValid", {31'd0, rdValid}, 32'd0);
    chk("rst_rdData",  rdData,           32'd0);
    chk("rst_irq",     {31'd0, irq},     32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    rd_issue("reset_level", 1'b0, 32'h0);
    rd_issue("reset_event", 1'b1, 32'h0);

    // Clean press on bit 0: stable rises on the 6th sampling edge.
    pinIn = 4'b0001;
    idle(5);
    chk("press_irq_early", {31'd0, irq}, 32'd0);
    rd_issue("press_level_at_edge", 1'b0, 32'h0);   // sampled pre-update
    chk("press_irq", {31'd0, irq}, {31'd0, EV});
    rd_issue("press_level", 1'b0, 32'h1);
    idle(1);
    chk("rdValid_drop", {31'd0, rdValid}, 32'd0);

    // Read-to-clear, then back-to-back reads.
    rd_issue("clr_event", 1'b1, EV ? 32'h1 : 32'h0);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    rd_issue("clr_event_again", 1'b1, 32'h0);
    rd_issue("b2b_level", 1'b0, 32'h1);

    // Glitch on bit 2 for three cycles: one short of the limit.
    pinIn = 4'b0101;
    idle(3);
    pinIn = 4'b0001;
    idle(8);
    chk("glitch_irq", {31'd0, irq}, 32'd0);
    rd_issue("glitch_level", 1'b0, 32'h1);
    rd_issue("glitch_event", 1'b1, 32'h0);

    // Simultaneous set and clear on bit 3, with bit 1 already pending.
    pinIn = 4'b0011;
    idle(8);
    chk("bit1_irq", {31'd0, irq}, {31'd0, EV});
    pinIn = 4'b1011;
    idle(5);
    rd_issue("simul_event", 1'b1, EV ? 32'h2 : 32'h0);
    chk("simul_irq", {31'd0, irq}, {31'd0, EV});
    rd_issue("simul_event_after", 1'b1, EV ? 32'h8 : 32'h0);
    chk("simul_irq_clr", {31'd0, irq}, 32'd0);
    rd_issue("simul_level", 1'b0, 32'hB);

    // Falling levels create no events.
    pinIn = 4'b0001;
    idle(8);
    rd_issue("fall_event", 1'b1, 32'h0);
    rd_issue("fall_level", 1'b0, 32'h1);

    // Build event=1010, start a pending count on bit 2, then reset.
    pinIn = 4'b1011;
    idle(8);
    chk("pre_rst_irq", {31'd0, irq}, {31'd0, EV});
    pinIn = 4'b1111;
    idle(3);
    rd   = 1'b1;
    addr = 1'b0;
    exp_q.push_back(32'hB);
    name_q.push_back("pre_rst_level");
    @(negedge clk);
    rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdValid", {31'd0, rdValid}, 32'd0);
    chk("async_rst_rdData",  rdData,           32'd0);
    chk("async_rst_irq",     {31'd0, irq},     32'd0);
    pinIn = '0;
    idle(2);
    rst_n = 1'b1;
    rd_issue("post_rst_level", 1'b0, 32'h0);
    rd_issue("post_rst_event", 1'b1, 32'h0);
    idle(3);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
